// File: rtl/pending_event_encoder.sv
`default_nettype none
// ============================================================================
// Module  : pending_event_encoder
// Purpose : Sticky rising-edge capture on a request bus, drained lowest index
//           first as a registered event position over valid/ready.
//           Define PEE_OVF_CNT_EN to add the saturating ovf_count output.
// Rev     : 1.0 - initial release
// ============================================================================
module pending_event_encoder #(
    parameter int WIDTH = 8
`ifdef PEE_OVF_CNT_EN
    ,
    parameter int OVF_W = 8
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         req_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(WIDTH)-1:0] evt_pos,
    output logic [WIDTH-1:0]         pending
`ifdef PEE_OVF_CNT_EN
    ,
    output logic [OVF_W-1:0]         ovf_count
`endif
);

    localparam int POS_W = $clog2(WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t       state_q, state_d;
    logic [WIDTH-1:0]  req_q, req_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic [POS_W-1:0]  evt_pos_q, evt_pos_d;

    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  load_mask;
    logic [POS_W-1:0]  low_idx;
    logic              slot_free;
    logic              load;

    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = POS_W'(i);
            end
        end
    end

    always_comb begin
        rise      = req_in & ~req_q;
        req_d     = req_in;
        slot_free = (state_q == EMPTY) || evt_ready;
        load      = slot_free && (|pending_q);
        load_mask = load ? (WIDTH'(1) << low_idx) : '0;
        // A rise on the bit being loaded re-arms it, so a second event follows.
        pending_d = (pending_q & ~load_mask) | rise;
        evt_pos_d = load ? low_idx : evt_pos_q;
        state_d   = state_q;
        if (slot_free) begin
            state_d = load ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            req_q     <= '0;
            pending_q <= '0;
            evt_pos_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            evt_pos_q <= evt_pos_d;
        end
    end

    assign evt_valid = (state_q == FULL);
    assign evt_pos   = evt_pos_q;
    assign pending   = pending_q;

`ifdef PEE_OVF_CNT_EN
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             merge;

    // One increment per cycle with any merge, regardless of how many bits merged.
    always_comb begin
        merge = |(rise & pending_q & ~load_mask);
        ovf_d = ovf_q;
        if (merge && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pending_event_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_pending_event_encoder
// Purpose : Directed self-checking bench for pending_event_encoder.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_pending_event_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] req_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_pos;
    logic [7:0] pending;
`ifdef PEE_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    pending_event_encoder #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_pos   (evt_pos),
        .pending   (pending)
`ifdef PEE_OVF_CNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [2:0] p,
                            input logic [7:0] pend);
        chk({tag, ".valid"},   {31'd0, evt_valid}, {31'd0, v});
        chk({tag, ".pos"},     {29'd0, evt_pos},   {29'd0, p});
        chk({tag, ".pending"}, {24'd0, pending},   {24'd0, pend});
    endtask

    initial begin
        reset     = 1'b1;
        req_in    = 8'hFF;
        evt_ready = 1'b1;

        // 1: line high across reset release gives one event per line, in order
        tick();
        chk_slot("rst", 1'b0, 3'd0, 8'h00);
`ifdef PEE_OVF_CNT_EN
        chk("rst.ovf", {24'd0, ovf_count}, 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick();
        chk_slot("t1.capture", 1'b0, 3'd0, 8'hFF);
        tick();
        chk_slot("t1.ev0", 1'b1, 3'd0, 8'hFE);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk_slot($sformatf("t1.ev%0d", k), 1'b1, 3'(k), 8'hFE << k);
        end
        req_in = 8'h00;
        tick();
        chk_slot("t1.drain", 1'b0, 3'd7, 8'h00);

        // 2: two-cycle latency, lowest first
        tick();
        req_in = 8'h24;
        tick();
        req_in = 8'h00;
        chk_slot("t2.pend", 1'b0, 3'd7, 8'h24);
        tick();
        chk_slot("t2.ev2", 1'b1, 3'd2, 8'h20);
        tick();
        chk_slot("t2.ev5", 1'b1, 3'd5, 8'h00);
        tick();
        chk_slot("t2.idle", 1'b0, 3'd5, 8'h00);

        // 3: stall holds the slot while pending accumulates
        evt_ready = 1'b0;
        req_in    = 8'h80;
        tick();
        req_in = 8'h00;
        tick();
        chk_slot("t3.load7", 1'b1, 3'd7, 8'h00);
        req_in = 8'h02;
        tick();
        req_in = 8'h00;
        tick();
        chk_slot("t3.stall", 1'b1, 3'd7, 8'h02);
        evt_ready = 1'b1;
        tick();
        chk_slot("t3.ev1", 1'b1, 3'd1, 8'h00);
        tick();
        chk_slot("t3.idle", 1'b0, 3'd1, 8'h00);

        // 4: second rise on an already pending bit merges
        evt_ready = 1'b0;
        req_in    = 8'h01;
        tick();
        req_in = 8'h00;
        tick();
        req_in = 8'h08;
        tick();
        req_in = 8'h00;
        tick();
`ifdef PEE_OVF_CNT_EN
        chk("t4.ovf0", {24'd0, ovf_count}, 32'd0);
`endif
        req_in = 8'h08;
        tick();
        req_in = 8'h00;
        chk_slot("t4.merged", 1'b1, 3'd0, 8'h08);
`ifdef PEE_OVF_CNT_EN
        chk("t4.ovf1", {24'd0, ovf_count}, 32'd1);
`endif
        evt_ready = 1'b1;
        tick();
        chk_slot("t4.ev3", 1'b1, 3'd3, 8'h00);
        tick();
        chk_slot("t4.single", 1'b0, 3'd3, 8'h00);

        // 5: rise on the bit being loaded yields a second event
        evt_ready = 1'b0;
        req_in    = 8'h04;
        tick();
        req_in = 8'h00;
        tick();
        req_in = 8'h01;
        tick();
        req_in = 8'h00;
        tick();
        chk_slot("t5.stall", 1'b1, 3'd2, 8'h01);
        evt_ready = 1'b1;
        req_in    = 8'h01;
        tick();
        req_in = 8'h00;
        chk_slot("t5.ev0a", 1'b1, 3'd0, 8'h01);
        tick();
        chk_slot("t5.ev0b", 1'b1, 3'd0, 8'h00);
        tick();
        chk_slot("t5.idle", 1'b0, 3'd0, 8'h00);
`ifdef PEE_OVF_CNT_EN
        chk("t5.ovf", {24'd0, ovf_count}, 32'd1);
`endif

        // 6: saturate the counter, then reset with a full slot and pending bits
        evt_ready = 1'b0;
        req_in    = 8'h01;
        tick();
        req_in = 8'h00;
        tick();
        req_in = 8'h08;
        tick();
        req_in = 8'h00;
        tick();
`ifdef PEE_OVF_CNT_EN
        for (int n = 0; n < 300; n++) begin
            req_in = 8'h08;
            tick();
            req_in = 8'h00;
            tick();
        end
        chk("t6.sat", {24'd0, ovf_count}, 32'd255);
`endif
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk_slot("t6.ev3", 1'b1, 3'd3, 8'h00);
        req_in = 8'h30;
        tick();
        req_in = 8'h00;
        tick();
        chk_slot("t6.pre", 1'b1, 3'd3, 8'h30);
`ifdef PEE_OVF_CNT_EN
        chk("t6.sat_hold", {24'd0, ovf_count}, 32'd255);
`endif
        reset = 1'b1;
        tick();
        chk_slot("t6.rst", 1'b0, 3'd0, 8'h00);
`ifdef PEE_OVF_CNT_EN
        chk("t6.ovf_rst", {24'd0, ovf_count}, 32'd0);
`endif
        reset = 1'b0;
        tick();
        chk_slot("t6.after", 1'b0, 3'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
